// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: simple dual-port RAM with one write port (A) and one read port (B),
// optional byte strobes, a valid-qualified read pipeline and a post-reset clear sequencer.
//
// state | meaning
// ------+------------------------------------------------------------
// CLEAR | sequencer zeroes one word per cycle; user ports ignored
// READY | normal operation; writes and reads accepted
//
// The first read stage samples the array on the acceptance edge. This lets a
// same-edge write be seen or not, depending on RDW_MODE. READ_LATENCY further
// stages follow it, so dvalb rises READ_LATENCY edges after acceptance.
module sdp_ram_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 1024,
    parameter int BYTE_WRITE   = 0,
    parameter int READ_LATENCY = 2,
    parameter int RDW_MODE     = 0,
    localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH),
    localparam int STRB_WIDTH  = (BYTE_WRITE != 0) ? DATA_WIDTH / 8 : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [STRB_WIDTH-1:0] wena,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic                  renb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  dvalb
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  clr_we;
    logic                  wr_en;
    logic                  rd_accept;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [DATA_WIDTH-1:0] rd_q [READ_LATENCY+1];
    logic [READ_LATENCY:0] rd_v;

    assign wr_in_range = ({1'b0, addra} < DEPTH_W);
    assign rd_in_range = ({1'b0, addrb} < DEPTH_W);

    // Expand the strobes into a bit mask; without byte writes one enable covers the word.
    generate
        if (BYTE_WRITE != 0) begin : g_byte_mask
            // Each strobe bit owns one byte lane.
            always_comb begin
                wr_mask = '0;
                for (int i = 0; i < STRB_WIDTH; i++) begin
                    wr_mask[8*i +: 8] = {8{wena[i]}};
                end
            end
        end else begin : g_word_mask
            assign wr_mask = {DATA_WIDTH{wena[0]}};
        end
    endgenerate

    // FSM state register and clear counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (clr_we) begin
                clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Next-state logic and port qualification. User traffic is gated off while clearing.
    always_comb begin
        state_d   = state_q;
        clr_we    = 1'b0;
        init_busy = 1'b1;
        wr_en     = 1'b0;
        rd_accept = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_d = READY;
                end
            end
            READY: begin
                init_busy = 1'b0;
                wr_en     = (wena != '0) && wr_in_range;
                rd_accept = renb;
            end
            default: state_d = CLEAR;
        endcase
    end

    // Merged write word: strobed bits from dina, the rest from the current contents.
    always_comb begin
        wr_merged = (mem[addra] & ~wr_mask) | (dina & wr_mask);
    end

    // Array write port. The clear sequencer has priority and owns the array while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[addra] <= wr_merged;
        end
    end

    // Read word selection: zero for out-of-range, write-first merge on a same-address hit.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[addrb];
            if ((RDW_MODE != 0) && wr_en && (addra == addrb)) begin
                rd_word = (mem[addrb] & ~wr_mask) | (dina & wr_mask);
            end
        end
    end

    // Read pipeline. A stage loads only when its predecessor is valid, so doutb holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            rd_v[0] <= rd_accept;
            if (rd_accept) begin
                rd_q[0] <= rd_word;
            end
            for (int i = 1; i <= READ_LATENCY; i++) begin
                rd_v[i] <= rd_v[i-1];
                if (rd_v[i-1]) begin
                    rd_q[i] <= rd_q[i-1];
                end
            end
        end
    end

    assign doutb = rd_q[READ_LATENCY];
    assign dvalb = rd_v[READ_LATENCY];

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// tb_sdp_ram_pipe: directed bench for sdp_ram_pipe.
// Instances a and b share stimulus: depth 20, byte writes, latency 3. They differ only in RDW_MODE.
// Instance c uses depth 16, a whole-word enable, latency 1 and write-first RDW.
module tb_sdp_ram_pipe;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [4:0]  addra = '0;
    logic [3:0]  wena  = '0;
    logic [31:0] dina  = '0;
    logic [4:0]  addrb = '0;
    logic        renb  = 1'b0;
    logic        busy_a, dvalb_a, busy_b, dvalb_b;
    logic [31:0] doutb_a, doutb_b;

    logic [3:0]  c_addra = '0;
    logic        c_wena  = 1'b0;
    logic [31:0] c_dina  = '0;
    logic [3:0]  c_addrb = '0;
    logic        c_renb  = 1'b0;
    logic        c_busy, c_dvalb;
    logic [31:0] c_doutb;

    int          n_asserts = 0;
    int          n_fail    = 0;

    logic [4:0]  rd_addr [32];
    logic [31:0] exp_a   [32];
    logic [31:0] exp_b   [32];

    sdp_ram_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(20), .BYTE_WRITE(1), .READ_LATENCY(RL), .RDW_MODE(0)) u_a (
        .clk(clk), .rst(rst), .init_busy(busy_a),
        .addra(addra), .wena(wena), .dina(dina),
        .addrb(addrb), .renb(renb), .doutb(doutb_a), .dvalb(dvalb_a)
    );

    sdp_ram_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(20), .BYTE_WRITE(1), .READ_LATENCY(RL), .RDW_MODE(1)) u_b (
        .clk(clk), .rst(rst), .init_busy(busy_b),
        .addra(addra), .wena(wena), .dina(dina),
        .addrb(addrb), .renb(renb), .doutb(doutb_b), .dvalb(dvalb_b)
    );

    sdp_ram_pipe #(.DATA_WIDTH(32), .MEM_DEPTH(16), .BYTE_WRITE(0), .READ_LATENCY(1), .RDW_MODE(1)) u_c (
        .clk(clk), .rst(rst), .init_busy(c_busy),
        .addra(c_addra), .wena(c_wena), .dina(c_dina),
        .addrb(c_addrb), .renb(c_renb), .doutb(c_doutb), .dvalb(c_dvalb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        addra = a;
        wena  = s;
        dina  = d;
        step();
        wena  = '0;
    endtask

    // Run a clear with user traffic applied, then check when each instance becomes ready.
    task automatic run_clear(input string tag);
        int first_a = 0;
        int first_b = 0;
        int first_c = 0;
        bit stray   = 1'b0;
        addra = 5'd3;  wena = 4'hF; dina = 32'hFFFF_FFFF; addrb = 5'd3; renb = 1'b1;
        c_addra = 4'd3; c_wena = 1'b1; c_dina = 32'hFFFF_FFFF; c_addrb = 4'd3; c_renb = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (dvalb_a || dvalb_b || c_dvalb) stray = 1'b1;
            if (first_a == 0 && !busy_a) begin first_a = k; wena = '0; renb = 1'b0; end
            if (first_b == 0 && !busy_b) first_b = k;
            if (first_c == 0 && !c_busy) begin first_c = k; c_wena = 1'b0; c_renb = 1'b0; end
        end
        check({tag, "_ready_edge_a"}, 32'(first_a), 32'd20);
        check({tag, "_ready_edge_b"}, 32'(first_b), 32'd20);
        check({tag, "_ready_edge_c"}, 32'(first_c), 32'd16);
        check({tag, "_stray_dvalb"}, 32'(stray), 32'd0);
    endtask

    // Back-to-back reads of rd_addr[0..n-1] on a/b; checks the dvalb window and the data.
    task automatic read_stream(input int n, input string tag);
        renb  = 1'b1;
        addrb = rd_addr[0];
        for (int j = 1; j <= n + RL + 1; j++) begin
            step();
            if (j < n) addrb = rd_addr[j];
            else       renb  = 1'b0;
            if (j >= 1 + RL && j <= n + RL) begin
                check({tag, "_dval_a"}, 32'(dvalb_a), 32'd1);
                check({tag, "_dval_b"}, 32'(dvalb_b), 32'd1);
                check({tag, "_dout_a"}, doutb_a, exp_a[j-1-RL]);
                check({tag, "_dout_b"}, doutb_b, exp_b[j-1-RL]);
            end else begin
                check({tag, "_idle_a"}, 32'(dvalb_a), 32'd0);
                check({tag, "_idle_b"}, 32'(dvalb_b), 32'd0);
            end
        end
    endtask

    // Same-edge write+read, then a read on the next edge of the same address.
    task automatic rdw(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] en,
                       input string tag);
        addra = a; wena = s; dina = d; addrb = a; renb = 1'b1;
        step();
        wena = '0;
        step();
        renb = 1'b0;
        step();
        step();
        check({tag, "_dval_a"}, 32'(dvalb_a), 32'd1);
        check({tag, "_same_edge_a"}, doutb_a, ea);
        check({tag, "_same_edge_b"}, doutb_b, eb);
        step();
        check({tag, "_next_dval_b"}, 32'(dvalb_b), 32'd1);
        check({tag, "_next_edge_a"}, doutb_a, en);
        check({tag, "_next_edge_b"}, doutb_b, en);
    endtask

    initial begin
        step();
        step();
        check("rst_busy_a", 32'(busy_a), 32'd1);
        check("rst_dout_a", doutb_a, 32'd0);
        check("rst_dval_a", 32'(dvalb_a), 32'd0);
        check("rst_busy_c", 32'(c_busy), 32'd1);
        check("rst_dout_c", c_doutb, 32'd0);
        rst = 1'b0;
        run_clear("init");

        for (int k = 0; k < 20; k++) begin
            addra = 5'(k); wena = 4'hF; dina = 32'hFFFF_FFFF;
            c_addra = 4'(k); c_wena = (k < 16); c_dina = 32'hFFFF_FFFF;
            step();
        end
        wena = '0;
        c_wena = 1'b0;
        rd_addr[0] = 5'd0;  exp_a[0] = 32'hFFFF_FFFF; exp_b[0] = 32'hFFFF_FFFF;
        rd_addr[1] = 5'd19; exp_a[1] = 32'hFFFF_FFFF; exp_b[1] = 32'hFFFF_FFFF;
        read_stream(2, "preload");

        rst = 1'b1;
        step();
        rst = 1'b0;
        run_clear("pulse");
        for (int i = 0; i < 20; i++) begin
            rd_addr[i] = 5'(i); exp_a[i] = 32'd0; exp_b[i] = 32'd0;
        end
        read_stream(20, "zero");

        for (int k = 0; k < 8; k++) write_a(5'(k), 4'hF, 32'h1000 + 32'(k));
        for (int k = 0; k < 8; k++) begin
            rd_addr[k] = 5'(k); exp_a[k] = 32'h1000 + 32'(k); exp_b[k] = 32'h1000 + 32'(k);
        end
        read_stream(8, "stream");
        check("stream_hold_a", doutb_a, 32'h0000_1007);

        write_a(5'd5, 4'hF, 32'h1122_3344);
        write_a(5'd5, 4'b0101, 32'hAABB_CCDD);
        rd_addr[0] = 5'd5; exp_a[0] = 32'h11BB_33DD; exp_b[0] = 32'h11BB_33DD;
        read_stream(1, "bytew");

        rdw(5'd9, 4'hF, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, "rdw_full");
        rdw(5'd9, 4'b0011, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_5678, 32'hCAFE_5678, "rdw_part");

        write_a(5'd20, 4'hF, 32'hDEAD_BEEF);
        rd_addr[0] = 5'd20; exp_a[0] = 32'd0;       exp_b[0] = 32'd0;
        rd_addr[1] = 5'd31; exp_a[1] = 32'd0;       exp_b[1] = 32'd0;
        rd_addr[2] = 5'd4;  exp_a[2] = 32'h1004;    exp_b[2] = 32'h1004;
        read_stream(3, "range");

        renb = 1'b1; addrb = 5'd0;
        step();
        addrb = 5'd1;
        step();
        renb = 1'b0;
        rst  = 1'b1;
        #1;
        check("midrst_busy_a", 32'(busy_a), 32'd1);
        check("midrst_dout_a", doutb_a, 32'd0);
        check("midrst_dout_b", doutb_b, 32'd0);
        check("midrst_dval_a", 32'(dvalb_a), 32'd0);
        step();
        rst = 1'b0;
        run_clear("midrst");

        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_clear("midclr");
        rd_addr[0] = 5'd9; exp_a[0] = 32'd0; exp_b[0] = 32'd0;
        rd_addr[1] = 5'd5; exp_a[1] = 32'd0; exp_b[1] = 32'd0;
        rd_addr[2] = 5'd0; exp_a[2] = 32'd0; exp_b[2] = 32'd0;
        read_stream(3, "after_rst");

        c_addra = 4'd3; c_wena = 1'b1; c_dina = 32'hA5A5_0003;
        step();
        c_wena = 1'b0;
        c_addrb = 4'd3; c_renb = 1'b1;
        step();
        c_renb = 1'b0;
        check("c_not_yet", 32'(c_dvalb), 32'd0);
        step();
        check("c_dval", 32'(c_dvalb), 32'd1);
        check("c_dout", c_doutb, 32'hA5A5_0003);
        step();
        check("c_dval_drop", 32'(c_dvalb), 32'd0);
        check("c_hold", c_doutb, 32'hA5A5_0003);

        c_addra = 4'd7; c_wena = 1'b1; c_dina = 32'h0000_0077; c_addrb = 4'd7; c_renb = 1'b1;
        step();
        c_wena = 1'b0; c_renb = 1'b0;
        step();
        check("c_rdw_dval", 32'(c_dvalb), 32'd1);
        check("c_rdw_dout", c_doutb, 32'h0000_0077);

        c_addra = 4'd3; c_dina = 32'd0; c_wena = 1'b0; c_addrb = 4'd3; c_renb = 1'b1;
        step();
        c_renb = 1'b0;
        step();
        check("c_nowrite", c_doutb, 32'hA5A5_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
